// File: rtl/read_pointer_handler_fwft_pkg.sv
// Shared FIFO helpers: pointer width and Gray/binary conversion.
// Conversions work on a fixed-width container; callers zero-extend in and truncate out.
package read_pointer_handler_fwft_pkg;

  localparam int GRAY_MAX_W = 32;

  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] binary2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended upper bits leave the low bits of the result unaffected.
  function automatic logic [GRAY_MAX_W-1:0] gray2binary(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/read_pointer_handler_fwft.sv
// Read-side pointer handler for the async FIFO with a first-word-fall-through
// output register, registered empty flag, occupancy estimate and almost-empty flag.
module read_pointer_handler_fwft
  import read_pointer_handler_fwft_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int AE_THRESH  = 2
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic [ADDR_WIDTH:0]   rq2_wptr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  rready,
  output logic [ADDR_WIDTH:0]   rptr,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic                  rempty,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH:0]   rlevel,
  output logic                  ralmost_empty
);

  localparam int             PW     = ptr_width(ADDR_WIDTH);
  localparam logic [PW-1:0]  AE_LVL = PW'(AE_THRESH);

  logic [PW-1:0] rbin;
  logic [PW-1:0] n_rbin;
  logic [PW-1:0] n_rgray;
  logic [PW-1:0] wbin;
  logic [PW-1:0] n_level;
  logic          pop;
  logic          n_rempty;
  logic          n_almost_empty;

  // A word leaves memory whenever one is available and the output slot is free or being drained.
  always_comb begin
    pop            = !rempty && (!rvalid || rready);
    n_rbin         = rbin + PW'(pop);
    n_rgray        = PW'(binary2gray(GRAY_MAX_W'(n_rbin)));
    wbin           = PW'(gray2binary(GRAY_MAX_W'(rq2_wptr)));
    n_level        = wbin - n_rbin;
    n_rempty       = (n_rgray == rq2_wptr);
    n_almost_empty = (n_level <= AE_LVL);
  end

  assign raddr = rbin[ADDR_WIDTH-1:0];

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin          <= '0;
      rptr          <= '0;
      rempty        <= 1'b1;
      rvalid        <= 1'b0;
      rdata         <= '0;
      rlevel        <= '0;
      ralmost_empty <= 1'b1;
    end else begin
      rbin          <= n_rbin;
      rptr          <= n_rgray;
      rempty        <= n_rempty;
      rlevel        <= n_level;
      ralmost_empty <= n_almost_empty;
      // Refill wins over drain, so a simultaneous consume and refill keeps rvalid high.
      if (pop) begin
        rdata  <= mem_rdata;
        rvalid <= 1'b1;
      end else if (rready) begin
        rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/read_pointer_handler_fwft.md
# read_pointer_handler_fwft

Read-side pointer and output controller for the asynchronous FIFO, paired with the write-side pointer handler in the write domain. Keeps the binary and Gray read pointers, derives a registered empty flag from the synchronized write pointer, and drives a first-word-fall-through output register with a valid/ready handshake toward the consumer. Also reports a registered occupancy estimate and an almost-empty flag.

## Interface
- ADDR_WIDTH, 4, memory address width; depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits
- DATA_WIDTH, 32, FIFO word width
- AE_THRESH, 2, ralmost_empty asserts when rlevel <= AE_THRESH

- rclk  in  1  read-domain clock; all logic on posedge
- rrst_n  in  1  asynchronous, active-low reset
- rq2_wptr  in  ADDR_WIDTH+1  Gray write pointer, already two-flop synchronized into rclk
- mem_rdata  in  DATA_WIDTH  combinational memory read data at raddr
- rready  in  1  consumer accepts rdata this cycle
- rptr  out  ADDR_WIDTH+1  registered Gray read pointer, sent to the write-domain synchronizer
- raddr  out  ADDR_WIDTH  low bits of binary read pointer
- rempty  out  1  registered: memory holds no unread word
- rvalid  out  1  output register holds a word
- rdata  out  DATA_WIDTH  output register
- rlevel  out  ADDR_WIDTH+1  registered occupancy estimate of memory (excludes output register)
- ralmost_empty  out  1  registered, rlevel <= AE_THRESH

## Operation
- Reset values: rptr=0, raddr=0 (rbin=0), rempty=1, rvalid=0, rdata=0, rlevel=0, ralmost_empty=1.
- pop = !rempty && (!rvalid || rready). Only pop advances the pointer; no pop while rempty.
- n_rbin = rbin + pop; n_rgray = (n_rbin>>1) ^ n_rbin; n_rempty = (n_rgray == rq2_wptr).
- On pop: rdata <= mem_rdata (word at current raddr), rvalid <= 1.
- No pop and rvalid && rready: rvalid <= 0, rdata holds last value.
- rvalid && !rready: rdata and rvalid held stable (no change under back-pressure).
- rready while !rvalid: ignored.
- Simultaneous consume and refill (rvalid && rready && !rempty): word handed over and replaced in the same edge; rvalid stays 1.
- rlevel <= gray2binary(rq2_wptr) - n_rbin, modulo 2^(ADDR_WIDTH+1); never exceeds 2^ADDR_WIDTH. Lags real occupancy (synchronizer latency), so it is conservative.
- Pointer wrap: rbin wraps from 2^(ADDR_WIDTH+1)-1 to 0; Gray sequence continues unbroken, empty compare stays correct across wrap.

## Timing
- rq2_wptr change at edge t -> rempty, rlevel update at t+1.
- rempty falls at t+1 with rvalid=0 -> pop in cycle t+1 -> rvalid=1, rdata valid, rptr/raddr advanced at t+2.
- Output register is the only read latency: 1 cycle from !rempty to rvalid.
- Sustained throughput: one word per cycle while rready=1 and memory non-empty.
- rptr changes by exactly one Gray bit per edge (single-step increment only).
- Async reset takes effect immediately mid-operation; outputs return to reset values; buffered word discarded. Deassertion is synchronized externally.

## Structure
- Shared fifo package: pointer width function (ADDR_WIDTH+1), Gray-conversion helpers if not used as modules.
- Reuse existing gray2binary (WIDTH=ADDR_WIDTH+1) for rq2_wptr in the level calculation; Gray encode of n_rbin inline or via binary2gray.
- Single module, no new sub-modules.

## Test plan
(ADDR_WIDTH=4, AE_THRESH=2)
- Reset, rq2_wptr=0 -> rempty=1, rvalid=0, rptr=0, rlevel=0, ralmost_empty=1; rready=1 causes no pointer movement.
- rq2_wptr=Gray(1)=00001, mem_rdata=0xA5 -> rempty=0 next edge, then rvalid=1, rdata=0xA5, raddr=1, rptr=00001, rempty=1.
- rq2_wptr=Gray(5), rready=1 continuously -> five consecutive words with rvalid=1 each cycle; rlevel 5,4,3,2,1,0; ralmost_empty asserts at rlevel=2.
- rvalid=1, rready=0 for 4 cycles with memory non-empty -> rdata unchanged, raddr unchanged; rready=1 -> new word next edge, rvalid stays 1.
- Stream 40 words with rq2_wptr advanced through wrap (rbin 31->0) -> data in order, rptr Gray single-bit steps, rempty correct at 32 and 40.
- Assert rrst_n=0 mid-stream with rvalid=1 -> outputs immediately at reset values; after release rempty=1 until rq2_wptr differs from 0.
